// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared playfield geometry, ball FSM state type and helpers
//                for the ball engine, paddles and computer player.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        MOVE   = 2'd1,
        SCORED = 2'd2
    } ball_state_t;

    localparam int c_SCREEN_W     = 640;
    localparam int c_SCREEN_H     = 480;
    localparam int c_BALL_HALF    = 4;
    localparam int c_PADDLE_HALF  = 32;
    localparam int c_LEFT_FACE_X  = 24;
    localparam int c_RIGHT_FACE_X = 616;

    // Signed absolute distance between two coordinates
    function automatic logic signed [31:0] abs_diff(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
        logic signed [31:0] d;
        d = a - b;
        return (d < 32'sd0) ? -d : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Free-running step divider. Counts enabled clocks and emits a
//                strobe on the cycle the count reaches period-1; periods
//                below 1 behave as 1. Disable freezes the count, clear zeroes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic signed [31:0] period,
    output logic               step
);

    logic signed [31:0] r_count;
    logic signed [31:0] w_period_eff;

    assign w_period_eff = (period < 32'sd1) ? 32'sd1 : period;
    // A shortened period with the count already past it fires immediately
    assign step = enable && (r_count >= (w_period_eff - 32'sd1));

    // Count register: clears on strobe or external clear, holds when disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 32'sd0;
        end else if (clear) begin
            r_count <= 32'sd0;
        end else if (enable) begin
            r_count <= step ? 32'sd0 : (r_count + 32'sd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ball_engine
//  Description : Pong ball position engine. Diagonal one-pixel steps, wall and
//                paddle bounces, miss detection with one-cycle score pulses.
//                Optional macro BALL_SPEEDUP_EN: paddle bounces shorten the
//                step period (loaded at serve, floored at ticks_per_px/4).
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = c_SCREEN_W,
    parameter int SCREEN_H     = c_SCREEN_H,
    parameter int BALL_HALF    = c_BALL_HALF,
    parameter int PADDLE_HALF  = c_PADDLE_HALF,
    parameter int LEFT_FACE_X  = c_LEFT_FACE_X,
    parameter int RIGHT_FACE_X = c_RIGHT_FACE_X
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_on,
    input  logic               serve,
    input  logic signed [31:0] ticks_per_px,
    input  logic signed [31:0] left_pos,
    input  logic signed [31:0] right_pos,
    output logic signed [31:0] ballX,
    output logic signed [31:0] ballY,
    output logic               dir_right,
    output logic               dir_down,
    output logic               left_score,
    output logic               right_score
);

    ball_state_t        r_state, w_state_next;
    logic signed [31:0] r_ball_x, r_ball_y, w_y_next, w_period;
    logic               r_dir_right, r_dir_down, r_left_score, r_right_score;
    logic               w_step, w_launch, w_dd_next;
    logic               w_hit_left, w_hit_right, w_left_scores, w_right_scores, w_miss;

    assign w_launch = (r_state == SERVE) && serve && game_on;

    tick_divider u_tick_divider (
        .clk    (clk),
        .reset  (reset),
        .enable ((r_state == MOVE) && game_on),
        .clear  (r_state != MOVE),
        .period (w_period),
        .step   (w_step)
    );

`ifdef BALL_SPEEDUP_EN
    logic signed [31:0] r_period, w_period_cut, w_period_floor;

    assign w_period_floor = ((ticks_per_px >>> 2) < 32'sd1) ? 32'sd1 : (ticks_per_px >>> 2);
    assign w_period_cut   = r_period - (r_period >>> 3);
    assign w_period       = r_period;

    // Serve latches the base period; each paddle bounce speeds the ball up
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period <= 32'sd1;
        end else if (w_launch) begin
            r_period <= (ticks_per_px < 32'sd1) ? 32'sd1 : ticks_per_px;
        end else if (w_step && (w_hit_left || w_hit_right)) begin
            r_period <= (w_period_cut < w_period_floor) ? w_period_floor : w_period_cut;
        end
    end
`else
    assign w_period = ticks_per_px;
`endif

    // Collision and miss decode, all on the pre-step position
    always_comb begin
        w_dd_next = r_dir_down;
        w_y_next  = r_ball_y;
        if (r_dir_down && (r_ball_y + BALL_HALF >= SCREEN_H - 1)) begin
            w_dd_next = 1'b0;
            w_y_next  = r_ball_y - 32'sd1;
        end else if (!r_dir_down && (r_ball_y - BALL_HALF <= 0)) begin
            w_dd_next = 1'b1;
            w_y_next  = r_ball_y + 32'sd1;
        end else begin
            w_y_next  = r_dir_down ? (r_ball_y + 32'sd1) : (r_ball_y - 32'sd1);
        end
        w_hit_left     = !r_dir_right && (r_ball_x - BALL_HALF <= LEFT_FACE_X) &&
                         (abs_diff(r_ball_y, left_pos) <= PADDLE_HALF + BALL_HALF);
        w_hit_right    = r_dir_right && (r_ball_x + BALL_HALF >= RIGHT_FACE_X) &&
                         (abs_diff(r_ball_y, right_pos) <= PADDLE_HALF + BALL_HALF);
        // Paddle contact wins over a miss in the same step
        w_right_scores = !r_dir_right && (r_ball_x - BALL_HALF <= 0) && !w_hit_left;
        w_left_scores  = r_dir_right && (r_ball_x + BALL_HALF >= SCREEN_W - 1) && !w_hit_right;
        w_miss         = w_right_scores || w_left_scores;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= SERVE;
        else        r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SERVE:   if (serve && game_on) w_state_next = MOVE;
            MOVE:    if (w_step && w_miss) w_state_next = SCORED;
            SCORED:  w_state_next = SERVE;
            default: w_state_next = SERVE;
        endcase
    end

    // Ball position, direction and score pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ball_x      <= SCREEN_W / 2;
            r_ball_y      <= SCREEN_H / 2;
            r_dir_right   <= 1'b1;
            r_dir_down    <= 1'b1;
            r_left_score  <= 1'b0;
            r_right_score <= 1'b0;
        end else begin
            r_left_score  <= 1'b0;
            r_right_score <= 1'b0;
            if (w_step) begin
                r_dir_down <= w_dd_next;
                if (w_miss) begin
                    r_ball_x      <= SCREEN_W / 2;
                    r_ball_y      <= SCREEN_H / 2;
                    r_dir_right   <= w_left_scores;
                    r_left_score  <= w_left_scores;
                    r_right_score <= w_right_scores;
                end else begin
                    r_ball_y <= w_y_next;
                    if (w_hit_left) begin
                        r_dir_right <= 1'b1;
                        r_ball_x    <= r_ball_x + 32'sd1;
                    end else if (w_hit_right) begin
                        r_dir_right <= 1'b0;
                        r_ball_x    <= r_ball_x - 32'sd1;
                    end else begin
                        r_ball_x    <= r_dir_right ? (r_ball_x + 32'sd1) : (r_ball_x - 32'sd1);
                    end
                end
            end
        end
    end

    assign ballX       = r_ball_x;
    assign ballY       = r_ball_y;
    assign dir_right   = r_dir_right;
    assign dir_down    = r_dir_down;
    assign left_score  = r_left_score;
    assign right_score = r_right_score;

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_engine
//  Description : Directed self-checking bench for ball_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_engine;

    logic               clk = 1'b0;
    logic               reset, game_on, serve;
    logic signed [31:0] ticks_per_px, left_pos, right_pos;
    logic signed [31:0] ballX, ballY;
    logic               dir_right, dir_down, left_score, right_score;
    int                 n_vec = 0;
    int                 n_err = 0;

    always #5 clk = ~clk;

    ball_engine dut (
        .clk          (clk),
        .reset        (reset),
        .game_on      (game_on),
        .serve        (serve),
        .ticks_per_px (ticks_per_px),
        .left_pos     (left_pos),
        .right_pos    (right_pos),
        .ballX        (ballX),
        .ballY        (ballY),
        .dir_right    (dir_right),
        .dir_down     (dir_down),
        .left_score   (left_score),
        .right_score  (right_score)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; serve = 1'b0; game_on = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        ticks_per_px = 32'sd4; left_pos = 32'sd240; right_pos = 32'sd240;
        do_reset();
        n_vec++;
        if ({ballX, ballY, dir_right, dir_down, left_score, right_score} !==
            {32'sd320, 32'sd240, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got x=%0d y=%0d r=%b d=%b ls=%b rs=%b, expected 320 240 1 1 0 0",
                     ballX, ballY, dir_right, dir_down, left_score, right_score);
        end
        // serve without game_on must not launch
        serve = 1'b1;
        repeat (6) tick();
        n_vec++;
        if (ballX !== 32'sd320 || ballY !== 32'sd240) begin
            n_err++;
            $display("FAIL serve_needs_game_on: got (%0d,%0d), expected (320,240)", ballX, ballY);
        end
    endtask

    task automatic test_first_step();
        game_on = 1'b1;
        tick();                 // SERVE -> MOVE
        serve = 1'b0;
        tick(); tick(); tick(); // count 0,1,2
        n_vec++;
        if (ballX !== 32'sd320) begin
            n_err++;
            $display("FAIL pre_first_step: got x=%0d, expected 320", ballX);
        end
        tick();                 // count 3 -> step
        n_vec++;
        if (ballX !== 32'sd321 || ballY !== 32'sd241) begin
            n_err++;
            $display("FAIL first_step: got (%0d,%0d), expected (321,241)", ballX, ballY);
        end
    endtask

    task automatic test_freeze();
        tick();                 // count now 1
        game_on = 1'b0;
        repeat (10) tick();
        n_vec++;
        if (ballX !== 32'sd321 || ballY !== 32'sd241) begin
            n_err++;
            $display("FAIL freeze_hold: got (%0d,%0d), expected (321,241)", ballX, ballY);
        end
        game_on = 1'b1;
        tick(); tick();         // count 2, 3
        n_vec++;
        if (ballX !== 32'sd321) begin
            n_err++;
            $display("FAIL resume_remaining: got x=%0d, expected 321", ballX);
        end
        tick();
        n_vec++;
        if (ballX !== 32'sd322 || ballY !== 32'sd242) begin
            n_err++;
            $display("FAIL resume_step: got (%0d,%0d), expected (322,242)", ballX, ballY);
        end
        repeat (4) tick();
        n_vec++;
        if (ballX !== 32'sd323) begin
            n_err++;
            $display("FAIL step_period4: got x=%0d, expected 323", ballX);
        end
    endtask

    task automatic test_period_change();
        tick(); tick();         // count 2
        ticks_per_px = 32'sd2;  // count already >= new period-1
        tick();
        n_vec++;
        if (ballX !== 32'sd324) begin
            n_err++;
            $display("FAIL period_shrink: got x=%0d, expected 324", ballX);
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({ballX, ballY, dir_right, dir_down} !== {32'sd320, 32'sd240, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got x=%0d y=%0d r=%b d=%b, expected 320 240 1 1",
                     ballX, ballY, dir_right, dir_down);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Launch at 1 px/clk from centre; right paddle parked at the impact row
    task automatic launch_fast(input logic signed [31:0] lpos);
        do_reset();
        ticks_per_px = 32'sd1; left_pos = lpos; right_pos = 32'sd418;
        serve = 1'b1; game_on = 1'b1;
        tick();
        serve = 1'b0;
    endtask

    task automatic test_walls_and_paddle();
        launch_fast(32'sd204);
        for (int i = 0; i < 2000; i++) begin
            if (ballY == 32'sd475 && dir_down) break;
            tick();
        end
        n_vec++;
        if (ballY !== 32'sd475 || ballX !== 32'sd555) begin
            n_err++;
            $display("FAIL reach_bottom: got (%0d,%0d), expected (555,475)", ballX, ballY);
        end
        tick();
        n_vec++;
        if ({ballX, ballY, dir_down} !== {32'sd556, 32'sd474, 1'b0}) begin
            n_err++;
            $display("FAIL bottom_bounce: got x=%0d y=%0d d=%b, expected 556 474 0", ballX, ballY, dir_down);
        end
        for (int i = 0; i < 2000; i++) begin
            if (ballX == 32'sd612 && dir_right) break;
            tick();
        end
        n_vec++;
        if (ballX !== 32'sd612 || ballY !== 32'sd418) begin
            n_err++;
            $display("FAIL reach_right: got (%0d,%0d), expected (612,418)", ballX, ballY);
        end
        tick();
        n_vec++;
        if ({ballX, ballY, dir_right, left_score} !== {32'sd611, 32'sd417, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL right_bounce: got x=%0d y=%0d r=%b ls=%b, expected 611 417 0 0",
                     ballX, ballY, dir_right, left_score);
        end
        for (int i = 0; i < 2000; i++) begin
            if (ballY == 32'sd4 && !dir_down) break;
            tick();
        end
        n_vec++;
        if (ballY !== 32'sd4 || ballX !== 32'sd198) begin
            n_err++;
            $display("FAIL reach_top: got (%0d,%0d), expected (198,4)", ballX, ballY);
        end
        tick();
        n_vec++;
        if ({ballX, ballY, dir_down} !== {32'sd197, 32'sd5, 1'b1}) begin
            n_err++;
            $display("FAIL top_bounce: got x=%0d y=%0d d=%b, expected 197 5 1", ballX, ballY, dir_down);
        end
        for (int i = 0; i < 2000; i++) begin
            if (ballX == 32'sd28 && !dir_right) break;
            tick();
        end
        n_vec++;
        if (ballX !== 32'sd28 || ballY !== 32'sd174) begin
            n_err++;
            $display("FAIL reach_left: got (%0d,%0d), expected (28,174)", ballX, ballY);
        end
        tick();
        n_vec++;
        if ({ballX, ballY, dir_right, right_score} !== {32'sd29, 32'sd175, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL left_bounce: got x=%0d y=%0d r=%b rs=%b, expected 29 175 1 0",
                     ballX, ballY, dir_right, right_score);
        end
    endtask

    task automatic test_miss();
        launch_fast(32'sd300);
        for (int i = 0; i < 3000; i++) begin
            if (ballX == 32'sd4 && !dir_right) break;
            tick();
        end
        n_vec++;
        if (ballX !== 32'sd4 || ballY !== 32'sd198 || right_score !== 1'b0) begin
            n_err++;
            $display("FAIL reach_edge: got (%0d,%0d) rs=%b, expected (4,198) 0", ballX, ballY, right_score);
        end
        tick();
        n_vec++;
        if ({right_score, left_score, ballX, ballY, dir_right} !==
            {1'b1, 1'b0, 32'sd320, 32'sd240, 1'b0}) begin
            n_err++;
            $display("FAIL miss_score: got rs=%b ls=%b x=%0d y=%0d r=%b, expected 1 0 320 240 0",
                     right_score, left_score, ballX, ballY, dir_right);
        end
        tick();
        n_vec++;
        if (right_score !== 1'b0) begin
            n_err++;
            $display("FAIL score_pulse_width: got rs=%b, expected 0", right_score);
        end
        repeat (5) tick();
        n_vec++;
        if (ballX !== 32'sd320 || ballY !== 32'sd240) begin
            n_err++;
            $display("FAIL serve_hold: got (%0d,%0d), expected (320,240)", ballX, ballY);
        end
        // relaunch with a period below 1, which must step every clock
        ticks_per_px = 32'sd0; serve = 1'b1;
        tick();
        serve = 1'b0;
        tick();
        n_vec++;
        if (ballX !== 32'sd319 || ballY !== 32'sd241) begin
            n_err++;
            $display("FAIL relaunch_left: got (%0d,%0d), expected (319,241)", ballX, ballY);
        end
        tick();
        n_vec++;
        if (ballX !== 32'sd318) begin
            n_err++;
            $display("FAIL period_zero: got x=%0d, expected 318", ballX);
        end
    endtask

    initial begin
        reset = 1'b0; serve = 1'b0; game_on = 1'b0;
        ticks_per_px = 32'sd4; left_pos = 32'sd240; right_pos = 32'sd240;
        test_reset();
        test_first_step();
        test_freeze();
        test_period_change();
        test_async_reset();
        test_walls_and_paddle();
        test_miss();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
